// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the decode stage and the execute-stage ALU.
//   - opcode constants for the supported subset
//   - alu_ctrl_t   : ALU operation encoding consumed by EX
//   - imm_src_t    : immediate format selector
//   - result_src_t : writeback result select
//   - id_ex_t      : control/index half of the ID/EX pipeline register
//   - imm_gen      : 32-bit sign-extended immediate builder
package riscv_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // All-zero value of this struct is the bubble encoding.
  typedef struct packed {
    logic        valid;
    logic        illegal;
    alu_ctrl_t   alu_control;
    logic        alu_src;
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    result_src_t result_src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_t;

  // Takes instr[31:7] only; opcode bits never contribute to an immediate.
  function automatic logic [31:0] imm_gen(input logic [31:7] ib, input imm_src_t sel);
    logic [31:0] imm;
    case (sel)
      IMM_S:   imm = {{20{ib[31]}}, ib[31:25], ib[11:7]};
      IMM_B:   imm = {{20{ib[31]}}, ib[7], ib[30:25], ib[11:8], 1'b0};
      IMM_J:   imm = {{12{ib[31]}}, ib[19:12], ib[20], ib[30:21], 1'b0};
      default: imm = {{20{ib[31]}}, ib[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_ex_ctrl_stage_decode.sv
// ctrl_decode: combinational RV32I-subset decoder.
// Inputs : opcode, funct3, funct7b5 (instr[30]).
// Outputs: ALU/writeback control fields, immediate format, illegal flag,
//          and which source registers the instruction actually reads
//          (used by the load-use compare).
module ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output alu_ctrl_t   alu_control,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output result_src_t result_src,
  output imm_src_t    imm_src,
  output logic        illegal,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  always_comb begin
    alu_control = ALU_ADD;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    result_src  = RES_ALU;
    imm_src     = IMM_I;
    illegal     = 1'b0;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;

    case (opcode)
      OP_LW: begin
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_MEM;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
        imm_src   = IMM_S;
        uses_rs2  = 1'b1;
      end
      OP_R: begin
        reg_write = 1'b1;
        uses_rs2  = 1'b1;
      end
      OP_I: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_BEQ: begin
        alu_control = ALU_SUB;
        branch      = 1'b1;
        imm_src     = IMM_B;
        uses_rs2    = 1'b1;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = RES_PC4;
        imm_src    = IMM_J;
        uses_rs1   = 1'b0;
      end
      default: illegal = 1'b1;
    endcase

    // opcode[5] separates R (sub allowed) from I-ALU (addi is never sub)
    if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        3'b000:  alu_control = (opcode[5] & funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_control = ALU_SLT;
        3'b110:  alu_control = ALU_OR;
        3'b111:  alu_control = ALU_AND;
        default: illegal = 1'b1;
      endcase
    end

    // An illegal instruction reaches EX as a harmless no-op carrying the flag.
    if (illegal) begin
      alu_control = ALU_ADD;
      alu_src     = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      result_src  = RES_ALU;
    end
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage: decode side of the ID/EX boundary.
// Decodes instr_d, extends its immediate, checks for a load-use hazard
// against the instruction in EX, and loads the ID/EX register.
// Inputs : clk, reset (async, active-high), instr_d/pc_d/valid_d,
//          rd1_d/rd2_d (regfile data), stall_e, flush_e.
// Outputs: stall_d, and the registered EX-side fields (*_e).
module id_ex_ctrl_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit LOAD_USE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            valid_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic            stall_e,
  input  logic            flush_e,
  output logic            stall_d,
  output logic            valid_e,
  output logic [2:0]      alu_control_e,
  output logic            alu_src_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic [1:0]      result_src_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] pc_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic            illegal_e
);

  alu_ctrl_t   dec_alu;
  result_src_t dec_res;
  imm_src_t    dec_imm_src;
  logic        dec_alu_src, dec_reg_write, dec_mem_write, dec_branch, dec_jump;
  logic        dec_illegal, uses_rs1, uses_rs2;

  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext_d;
  logic            load_use;

  id_ex_t          ex_q, ex_d;
  logic [XLEN-1:0] imm_q, rd1_q, rd2_q, pc_q;

  ctrl_decode u_decode (
    .opcode      (instr_d[6:0]),
    .funct3      (instr_d[14:12]),
    .funct7b5    (instr_d[30]),
    .alu_control (dec_alu),
    .alu_src     (dec_alu_src),
    .reg_write   (dec_reg_write),
    .mem_write   (dec_mem_write),
    .branch      (dec_branch),
    .jump        (dec_jump),
    .result_src  (dec_res),
    .imm_src     (dec_imm_src),
    .illegal     (dec_illegal),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2)
  );

  assign rs1_d     = instr_d[19:15];
  assign rs2_d     = instr_d[24:20];
  assign rd_d      = instr_d[11:7];
  assign imm32     = imm_gen(instr_d[31:7], dec_imm_src);
  assign imm_ext_d = XLEN'($signed(imm32));

  // Bubbles carry valid=0 and rd=0, so they can never trigger this.
  assign load_use = LOAD_USE_EN && ex_q.valid && (ex_q.result_src == RES_MEM)
                    && (ex_q.rd != 5'd0) && valid_d
                    && ((uses_rs1 && (ex_q.rd == rs1_d)) ||
                        (uses_rs2 && (ex_q.rd == rs2_d)));

  assign stall_d = ~flush_e & (stall_e | load_use);

  always_comb begin
    ex_d = '0;
    if (valid_d) begin
      ex_d.valid       = 1'b1;
      ex_d.illegal     = dec_illegal;
      ex_d.alu_control = dec_alu;
      ex_d.alu_src     = dec_alu_src;
      ex_d.reg_write   = dec_reg_write;
      ex_d.mem_write   = dec_mem_write;
      ex_d.branch      = dec_branch;
      ex_d.jump        = dec_jump;
      ex_d.result_src  = dec_res;
      ex_d.rs1         = rs1_d;
      ex_d.rs2         = rs2_d;
      ex_d.rd          = rd_d;
    end
  end

  // flush beats stall: a squashed instruction must not be held in EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      imm_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      pc_q  <= '0;
    end else if (flush_e || (!stall_e && load_use)) begin
      ex_q  <= '0;
      imm_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      pc_q  <= '0;
    end else if (!stall_e) begin
      ex_q  <= ex_d;
      imm_q <= valid_d ? imm_ext_d : '0;
      rd1_q <= valid_d ? rd1_d     : '0;
      rd2_q <= valid_d ? rd2_d     : '0;
      pc_q  <= valid_d ? pc_d      : '0;
    end
  end

  assign valid_e       = ex_q.valid;
  assign illegal_e     = ex_q.illegal;
  assign alu_control_e = ex_q.alu_control;
  assign alu_src_e     = ex_q.alu_src;
  assign reg_write_e   = ex_q.reg_write;
  assign mem_write_e   = ex_q.mem_write;
  assign branch_e      = ex_q.branch;
  assign jump_e        = ex_q.jump;
  assign result_src_e  = ex_q.result_src;
  assign rs1_e         = ex_q.rs1;
  assign rs2_e         = ex_q.rs2;
  assign rd_e          = ex_q.rd;
  assign imm_ext_e     = imm_q;
  assign rd1_e         = rd1_q;
  assign rd2_e         = rd2_q;
  assign pc_e          = pc_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Scoreboard bench for id_ex_ctrl_stage: each driven decode cycle pushes the
// hand-computed stall_d for that cycle and the EX contents after the edge.
module tb_id_ex_ctrl_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = '0, pc_d = '0, rd1_d = '0, rd2_d = '0;
  logic        valid_d = 1'b0, stall_e = 1'b0, flush_e = 1'b0;
  logic        stall_d, valid_e, alu_src_e, reg_write_e, mem_write_e;
  logic        branch_e, jump_e, illegal_e;
  logic [2:0]  alu_control_e;
  logic [1:0]  result_src_e;
  logic [31:0] imm_ext_e, rd1_e, rd2_e, pc_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_ctrl_stage #(.XLEN(32), .LOAD_USE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .stall_e(stall_e), .flush_e(flush_e),
    .stall_d(stall_d), .valid_e(valid_e), .alu_control_e(alu_control_e),
    .alu_src_e(alu_src_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .result_src_e(result_src_e),
    .imm_ext_e(imm_ext_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .illegal_e(illegal_e)
  );

  typedef struct {
    logic        stall;
    logic        valid, illegal;
    logic [2:0]  alu;
    logic        alu_src, reg_write, mem_write, branch, jump;
    logic [1:0]  res;
    logic        imm_care;
    logic [31:0] imm, rd1, rd2, pc;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(logic st, logic v, logic il, logic [2:0] alu, logic asrc,
                              logic rw, logic mw, logic br, logic jp, logic [1:0] res,
                              logic ic, logic [31:0] imm, logic [31:0] a, logic [31:0] b,
                              logic [31:0] pc, logic [4:0] s1, logic [4:0] s2, logic [4:0] d);
    exp_t e;
    e.stall = st; e.valid = v; e.illegal = il; e.alu = alu; e.alu_src = asrc;
    e.reg_write = rw; e.mem_write = mw; e.branch = br; e.jump = jp; e.res = res;
    e.imm_care = ic; e.imm = imm; e.rd1 = a; e.rd2 = b; e.pc = pc;
    e.rs1 = s1; e.rs2 = s2; e.rd = d;
    return e;
  endfunction

  function automatic exp_t bubble(logic st);
    return mk(st, 0,0, 3'd0, 0,0,0,0,0, 2'd0, 1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic se, input logic fe, input exp_t e);
    @(negedge clk);
    instr_d = ins; pc_d = pc; valid_d = v; rd1_d = a; rd2_d = b;
    stall_e = se; flush_e = fe;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  // Monitor: stall_d is sampled mid-cycle with that cycle's inputs, EX fields
  // just after the following rising edge.
  initial begin : monitor
    int   idx = 0;
    logic st;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        st = stall_d;
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("stall_d",       idx, 32'(st),            32'(e.stall));
        chk("valid_e",       idx, 32'(valid_e),       32'(e.valid));
        chk("illegal_e",     idx, 32'(illegal_e),     32'(e.illegal));
        chk("alu_control_e", idx, 32'(alu_control_e), 32'(e.alu));
        chk("alu_src_e",     idx, 32'(alu_src_e),     32'(e.alu_src));
        chk("reg_write_e",   idx, 32'(reg_write_e),   32'(e.reg_write));
        chk("mem_write_e",   idx, 32'(mem_write_e),   32'(e.mem_write));
        chk("branch_e",      idx, 32'(branch_e),      32'(e.branch));
        chk("jump_e",        idx, 32'(jump_e),        32'(e.jump));
        chk("result_src_e",  idx, 32'(result_src_e),  32'(e.res));
        if (e.imm_care) chk("imm_ext_e", idx, imm_ext_e, e.imm);
        chk("rd1_e",         idx, rd1_e,              e.rd1);
        chk("rd2_e",         idx, rd2_e,              e.rd2);
        chk("pc_e",          idx, pc_e,               e.pc);
        chk("rs1_e",         idx, 32'(rs1_e),         32'(e.rs1));
        chk("rs2_e",         idx, 32'(rs2_e),         32'(e.rs2));
        chk("rd_e",          idx, 32'(rd_e),          32'(e.rd));
        idx++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t e_sw;
    #1;
    chk("rst_valid_e",   0, 32'(valid_e),     32'd0);
    chk("rst_reg_write", 0, 32'(reg_write_e), 32'd0);
    chk("rst_stall_d",   0, 32'(stall_d),     32'd0);
    chk("rst_rd_e",      0, 32'(rd_e),        32'd0);
    #11 reset = 1'b0;

    // add x3,x1,x2 ; sub x5,x6,x7 ; slti x1,x2,-1
    drive(32'h002081B3, 32'h100, 1, 5, 7, 0, 0,
          mk(0, 1,0, 3'b000, 0,1,0,0,0, 2'b00, 0, 0, 5, 7, 32'h100, 1, 2, 3));
    drive(32'h407302B3, 32'h104, 1, 10, 3, 0, 0,
          mk(0, 1,0, 3'b001, 0,1,0,0,0, 2'b00, 0, 0, 10, 3, 32'h104, 6, 7, 5));
    drive(32'hFFF12093, 32'h108, 1, 4, 0, 0, 0,
          mk(0, 1,0, 3'b101, 1,1,0,0,0, 2'b00, 1, 32'hFFFFFFFF, 4, 0, 32'h108, 2, 31, 1));
    // lw x4,8(x0) then add x5,x4,x4: one bubble, then the add
    drive(32'h00802203, 32'h10C, 1, 0, 32'h55, 0, 0,
          mk(0, 1,0, 3'b000, 1,1,0,0,0, 2'b01, 1, 8, 0, 32'h55, 32'h10C, 0, 8, 4));
    drive(32'h004202B3, 32'h110, 1, 9, 9, 0, 0, bubble(1));
    drive(32'h004202B3, 32'h110, 1, 9, 9, 0, 0,
          mk(0, 1,0, 3'b000, 0,1,0,0,0, 2'b00, 0, 0, 9, 9, 32'h110, 4, 4, 5));
    // same pair, flushed in the hazard cycle
    drive(32'h00802203, 32'h200, 1, 0, 32'h55, 0, 0,
          mk(0, 1,0, 3'b000, 1,1,0,0,0, 2'b01, 1, 8, 0, 32'h55, 32'h200, 0, 8, 4));
    drive(32'h004202B3, 32'h204, 1, 9, 9, 0, 1, bubble(0));
    // lw x0 then add x5,x0,x0: no hazard on x0
    drive(32'h00802003, 32'h208, 1, 0, 0, 0, 0,
          mk(0, 1,0, 3'b000, 1,1,0,0,0, 2'b01, 1, 8, 0, 0, 32'h208, 0, 8, 0));
    drive(32'h000002B3, 32'h20C, 1, 0, 0, 0, 0,
          mk(0, 1,0, 3'b000, 0,1,0,0,0, 2'b00, 0, 0, 0, 0, 32'h20C, 0, 0, 5));
    // sw x2,-4(x1) held by stall_e for 3 cycles
    e_sw = mk(0, 1,0, 3'b000, 1,0,1,0,0, 2'b00, 1, 32'hFFFFFFFC, 32'h1000, 32'hAB,
              32'h300, 1, 2, 28);
    drive(32'hFE20AE23, 32'h300, 1, 32'h1000, 32'hAB, 0, 0, e_sw);
    e_sw.stall = 1'b1;
    for (int i = 0; i < 3; i++) drive(32'h002081B3, 32'h304, 1, 32'h77, 32'h88, 1, 0, e_sw);
    drive(32'h002081B3, 32'h304, 1, 32'h77, 32'h88, 0, 0,
          mk(0, 1,0, 3'b000, 0,1,0,0,0, 2'b00, 0, 0, 32'h77, 32'h88, 32'h304, 1, 2, 3));
    // beq x1,x2,-4 ; jal x1,+16
    drive(32'hFE208EE3, 32'h308, 1, 3, 3, 0, 0,
          mk(0, 1,0, 3'b001, 0,0,0,1,0, 2'b00, 1, 32'hFFFFFFFC, 3, 3, 32'h308, 1, 2, 29));
    drive(32'h010000EF, 32'h30C, 1, 0, 0, 0, 0,
          mk(0, 1,0, 3'b000, 0,1,0,0,1, 2'b10, 1, 32'h10, 0, 0, 32'h30C, 0, 16, 1));
    // unknown opcode, then valid_d=0
    drive(32'h0000007F, 32'h310, 1, 1, 2, 0, 0,
          mk(0, 1,1, 3'b000, 0,0,0,0,0, 2'b00, 0, 0, 1, 2, 32'h310, 0, 0, 0));
    drive(32'h002081B3, 32'h314, 0, 1, 2, 0, 0, bubble(0));
    // lw x4 then sw x4,0(x1): hazard through rs2 only
    drive(32'h00802203, 32'h400, 1, 0, 0, 0, 0,
          mk(0, 1,0, 3'b000, 1,1,0,0,0, 2'b01, 1, 8, 0, 0, 32'h400, 0, 8, 4));
    drive(32'h0040A023, 32'h404, 1, 32'h20, 32'h30, 0, 0, bubble(1));
    drive(32'h0040A023, 32'h404, 1, 32'h20, 32'h30, 0, 0,
          mk(0, 1,0, 3'b000, 1,0,1,0,0, 2'b00, 1, 0, 32'h20, 32'h30, 32'h404, 1, 4, 0));
    // R-type with unsupported funct3 001
    drive(32'h002091B3, 32'h408, 1, 6, 7, 0, 0,
          mk(0, 1,1, 3'b000, 0,0,0,0,0, 2'b00, 0, 0, 6, 7, 32'h408, 1, 2, 3));
    // live add in EX before the mid-stream reset
    drive(32'h002081B3, 32'h500, 1, 32'h11, 32'h22, 0, 0,
          mk(0, 1,0, 3'b000, 0,1,0,0,0, 2'b00, 0, 0, 32'h11, 32'h22, 32'h500, 1, 2, 3));
    wait_drain();

    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_valid_e",   1, 32'(valid_e),     32'd0);
    chk("mid_rst_reg_write", 1, 32'(reg_write_e), 32'd0);
    chk("mid_rst_rd_e",      1, 32'(rd_e),        32'd0);
    chk("mid_rst_rd1_e",     1, rd1_e,            32'd0);
    chk("mid_rst_pc_e",      1, pc_e,             32'd0);
    chk("mid_rst_stall_d",   1, 32'(stall_d),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl_stage.md
Name: id_ex_ctrl_stage

Overview:
- Decode-side producer of the execute-stage ALU interface.
- Decodes the fetched RV32I subset into control fields: alu_control, alu_src, write enables, result select, and the extended immediate. Registers them with operands into the ID/EX pipeline register.
- Detects load-use hazards against the instruction already in EX; inserts bubbles and stalls decode.
- Sits between the fetch/regfile read and the ALU in EX.

Parameters:
- XLEN, 32, datapath width of pc, operands and immediate.
- LOAD_USE_EN, 1, 1 = internal load-use detection/bubble; 0 = never self-stall (external hazard unit handles it).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- instr_d  input  32  instruction in decode.
- pc_d  input  XLEN  pc of instr_d.
- valid_d  input  1  instr_d is a real instruction.
- rd1_d, rd2_d  input  XLEN  regfile read data for rs1/rs2.
- stall_e  input  1  EX cannot accept; hold ID/EX.
- flush_e  input  1  squash ID/EX (taken branch/jump).
- stall_d  output  1  decode must hold instr_d next cycle.
- valid_e  output  1  EX slot holds a live instruction.
- alu_control_e  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- alu_src_e  output  1  1 = ALU b is imm_ext_e.
- reg_write_e, mem_write_e, branch_e, jump_e  output  1 each  control flags.
- result_src_e  output  2  00 ALU, 01 memory, 10 pc+4.
- imm_ext_e, rd1_e, rd2_e, pc_e  output  XLEN  registered immediate/operands/pc.
- rs1_e, rs2_e, rd_e  output  5  register indices for forwarding.
- illegal_e  output  1  unsupported opcode reached EX.

Behaviour:
- Supported opcodes:
  - lw 0000011, I-imm, add, result 01.
  - sw 0100011, S-imm, add, mem_write.
  - R-type 0110011.
  - I-ALU 0010011.
  - beq 1100011, B-imm, sub, branch.
  - jal 1101111, J-imm, result 10, jump.
- R/I funct3 mapping:
  - 000 → add, or sub when op[5]&funct7[5] (addi is never sub).
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - Any other funct3 → illegal.
- alu_src = 1 for lw, sw, I-ALU. Immediates are sign-extended from instr[31] to XLEN; B/J immediates have LSB 0.
- Illegal (unknown opcode/funct3, valid_d=1): illegal_e=1, valid_e=1, all write/branch/jump flags 0, alu_control 000.
- Reset (async): every _e output 0, valid_e 0, stall_d 0.
- Register update priority per rising edge:
  - flush_e → bubble (valid_e=0, all flags 0, illegal_e=0; data fields don't-care, drive 0).
  - else stall_e → hold all _e fields unchanged.
  - else load_use → bubble.
  - else capture decode outputs; valid_e=valid_d. valid_d=0 captures a bubble.
- load_use (combinational) = LOAD_USE_EN & valid_e & result_src_e==01 & rd_e!=0 & valid_d & ((uses_rs1 & rd_e==rs1_d) | (uses_rs2 & rd_e==rs2_d)).
  - uses_rs1: all except jal.
  - uses_rs2: R, sw, beq.
- stall_d = ~flush_e & (stall_e | load_use).
- Latency: one cycle decode → EX. A load-use costs exactly one bubble, because the next cycle the load has left EX.
- Bubbles: rd_e=0, reg_write_e=0, mem_write_e=0. A bubble never matches a hazard.
- Reset mid-operation clears the EX slot immediately; no partial hold survives.

Decomposition:
- riscv_pkg holds:
  - opcode localparams.
  - alu_ctrl enum (ADD=000, SUB=001, AND=010, OR=011, SLT=101), shared with the ALU.
  - imm_src enum (I, S, B, J).
  - result_src enum.
  - id_ex_t packed struct for the pipeline register.
- Sub-module ctrl_decode: purely combinational opcode/funct → control fields + imm_src. The stage instantiates it plus the imm extender, hazard compare and register.

Test Plan:
- add x3,x1,x2 (0x002081B3), rd1_d=5, rd2_d=7 → next cycle: alu_control_e=000, reg_write_e=1, alu_src_e=0, rd_e=3, rd1_e=5, rd2_e=7, valid_e=1.
- sub x5,x6,x7 (0x407302B3) → alu_control_e=001; slti x1,x2,-1 (0xFFF12093) → alu_control_e=101, alu_src_e=1, imm_ext_e=0xFFFFFFFF.
- lw x4,8(x0) (0x00802203) then add x5,x4,x4 → cycle 2: stall_d=1, bubble (valid_e=0). Cycle 3: add in EX, stall_d=0.
- The same load-use pair with flush_e=1 in the hazard cycle → stall_d=0, valid_e=0. Also: lw to x0 followed by add x5,x0,x0 → no stall.
- stall_e=1 for 3 cycles while sw x2,-4(x1) (0xFE20AE23) sits in EX → _e fields constant, imm_ext_e=0xFFFFFFFC, mem_write_e=1, stall_d=1.
- Opcode 0x0000007F → illegal_e=1, reg_write_e=0. Assert reset mid-stream → all outputs 0 asynchronously, before the next clock edge.
